// File: rtl/rv_core_pkg.sv
// rv_core_pkg - definitions shared by the RISC-V core fetch path.
//   NOP_INST   : canonical NOP (addi x0,x0,0)
//   ld_state_t : program-loader state encoding (LD_IDLE=0, LD_LOAD=1)
//   ofs_w()    : byte-offset width of an instruction word of a given bit width
package rv_core_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_LOAD = 1'b1
  } ld_state_t;

  function automatic int unsigned ofs_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// inst_mem_loader - in-system program loader for inst_mem_sync.
// Writes DEPTH consecutive words starting at word 0, one per ld_valid.
//   clk, rst_n : clock, synchronous active-low reset
//   ld_start   : (re)start a load at word 0; ld_valid in that cycle is ignored
//   ld_valid   : write request for the current pointer
//   wr_en      : memory write strobe (combinational)
//   wr_ptr     : word address of the write
//   busy       : loader is in LD_LOAD
//   done       : one-cycle pulse after the last word has been written
module inst_mem_loader
  import rv_core_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_start,
  input  logic             ld_valid,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic             busy,
  output logic             done
);

  ld_state_t        state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LD_IDLE;
      ptr   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    wr_en   = 1'b0;
    unique case (state)
      LD_IDLE: begin
        if (ld_start) begin
          state_n = LD_LOAD;
          ptr_n   = '0;
        end
      end
      LD_LOAD: begin
        if (ld_start) begin
          ptr_n = '0;
        end else if (ld_valid) begin
          wr_en = 1'b1;
          if (ptr == PTR_W'(DEPTH - 1)) begin
            state_n = LD_IDLE;
            ptr_n   = '0;
            done_n  = 1'b1;
          end else begin
            ptr_n = ptr + 1'b1;
          end
        end
      end
      default: state_n = LD_IDLE;
    endcase
  end

  assign wr_ptr = ptr;
  assign busy   = (state == LD_LOAD);

endmodule

// File: rtl/inst_mem_sync.sv
// inst_mem_sync - synchronous instruction memory with registered read,
// valid/ready fetch and response handshakes and a fault flag.
// Build option: IMEM_LOAD_EN adds the ld_* ports and a writable memory.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_valid/ready/addr    : fetch request (byte address)
//   resp_valid/ready        : response handshake (one-entry output register)
//   resp_inst, resp_fault   : fetched word, misaligned/out-of-range flag
//   ld_start/valid/data     : [IMEM_LOAD_EN] program loader input
//   ld_busy, ld_done        : [IMEM_LOAD_EN] loader status
module inst_mem_sync
  import rv_core_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_inst,
  output logic              resp_fault
`ifdef IMEM_LOAD_EN
  ,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_busy,
  output logic              ld_done
`endif
);

  localparam int unsigned OFS_W  = ofs_w(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - OFS_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic              fault;
  logic              accept;
  logic              busy;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = DATA_W'(NOP_INST);
  end

`ifdef IMEM_LOAD_EN
  logic              ld_we;
  logic [MEM_AW-1:0] ld_ptr;

  inst_mem_loader #(
    .DEPTH (DEPTH),
    .PTR_W (MEM_AW)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .wr_en    (ld_we),
    .wr_ptr   (ld_ptr),
    .busy     (busy),
    .done     (ld_done)
  );

  assign ld_busy = busy;

  // Memory contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_ptr] <= ld_data;
  end
`else
  assign busy = 1'b0;
`endif

  assign word_idx  = req_addr[ADDR_W-1:OFS_W];
  assign fault     = (req_addr[OFS_W-1:0] != '0) || (32'(word_idx) >= DEPTH);
  assign req_ready = (!resp_valid || resp_ready) && !busy;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_inst  <= DATA_W'(NOP_INST);
      resp_fault <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_fault <= fault;
      resp_inst  <= fault ? DATA_W'(NOP_INST) : mem[word_idx[MEM_AW-1:0]];
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
module tb_inst_mem_sync;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [DATA_W-1:0] resp_inst;
  logic              resp_fault;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_busy_o;
  logic              ld_done_o;

  always #5 clk = ~clk;

  inst_mem_sync #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_fault (resp_fault)
`ifdef IMEM_LOAD_EN
    ,
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_busy    (ld_busy_o),
    .ld_done    (ld_done_o)
`endif
  );

`ifndef IMEM_LOAD_EN
  assign ld_busy_o = 1'b0;
  assign ld_done_o = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] mmem [DEPTH];
  bit          m_valid = 0;
  logic [31:0] m_inst  = NOP;
  bit          m_fault = 0;
  bit          m_busy  = 0;
  int          m_ptr   = 0;
  bit          m_done  = 0;
  bit          model_on = 0;

  initial for (int i = 0; i < DEPTH; i++) mmem[i] = NOP;

  initial begin
    bit          s_rst, s_rv, s_rr, s_st, s_lv, acc;
    logic [7:0]  s_addr;
    logic [31:0] s_data;
    int          idx;
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("resp_valid", {63'b0, resp_valid}, {63'b0, m_valid});
        if (m_valid) begin
          check("resp_inst", {32'b0, resp_inst}, {32'b0, m_inst});
          check("resp_fault", {63'b0, resp_fault}, {63'b0, m_fault});
        end
        check("req_ready", {63'b0, req_ready}, {63'b0, (!m_valid || resp_ready) && !m_busy});
`ifdef IMEM_LOAD_EN
        check("ld_busy", {63'b0, ld_busy_o}, {63'b0, m_busy});
        check("ld_done", {63'b0, ld_done_o}, {63'b0, m_done});
`endif
      end
      s_rst = rst_n; s_rv = req_valid; s_rr = resp_ready; s_addr = req_addr;
      s_st = ld_start; s_lv = ld_valid; s_data = ld_data;
      acc = s_rv && (!m_valid || s_rr) && !m_busy;
      @(posedge clk);
      if (!s_rst) begin
        m_valid = 0; m_inst = NOP; m_fault = 0;
        m_busy = 0; m_ptr = 0; m_done = 0;
      end else begin
        if (acc) begin
          idx = int'(s_addr) / 4;
          m_valid = 1;
          if ((s_addr % 4) != 0 || idx >= DEPTH) begin
            m_inst = NOP; m_fault = 1;
          end else begin
            m_inst = mmem[idx]; m_fault = 0;
          end
        end else if (s_rr) begin
          m_valid = 0;
        end
        m_done = 0;
`ifdef IMEM_LOAD_EN
        if (!m_busy) begin
          if (s_st) begin m_busy = 1; m_ptr = 0; end
        end else if (s_st) begin
          m_ptr = 0;
        end else if (s_lv) begin
          mmem[m_ptr] = s_data;
          if (m_ptr == DEPTH - 1) begin m_busy = 0; m_done = 1; m_ptr = 0; end
          else m_ptr++;
        end
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [7:0] a);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic rand_traffic(input int n, input bit with_loader);
    for (int k = 0; k < n; k++) begin
      int sel;
      sel = $urandom_range(0, 99);
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (sel < 70)      req_addr = 8'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 85) req_addr = 8'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else               req_addr = 8'($urandom_range(DEPTH, 63) * 4);
      if (with_loader) begin
        ld_start = ($urandom_range(0, 199) == 0);
        ld_valid = ($urandom_range(0, 1) == 1);
        ld_data  = $urandom;
      end
      tick();
    end
    ld_start = 1'b0; ld_valid = 1'b0;
  endtask

`ifdef IMEM_LOAD_EN
  task automatic load_words(input logic [31:0] base, input int n, output int dones);
    int i;
    int budget;
    i = 0; budget = 0; dones = 0;
    while (i < n && budget < 1000) begin
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_data  = base + 32'(i);
      tick();
      if (ld_valid) i++;
      if (ld_done_o) dones++;
      budget++;
    end
    ld_valid = 1'b0;
    if (budget >= 1000) check("load_budget", 64'(budget), 64'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      if (ld_done_o) dones++;
    end
  endtask
`endif

  initial begin
    logic [31:0] held;
    int dones;
    // power-on reset
    rst_n = 1'b0;
    tick(); tick();
    model_on = 1;
    check("por_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("por_resp_inst", {32'b0, resp_inst}, {32'b0, NOP});
    rst_n = 1'b1;

    rand_traffic(60, 0);

    // reset mid-traffic with a pending request
    req_valid = 1'b1; req_addr = 8'h04; resp_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_resp_inst", {32'b0, resp_inst}, {32'b0, NOP});
    check("rst_resp_fault", {63'b0, resp_fault}, 64'd0);
    rst_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    tick();

    // back-to-back streaming: one response per cycle
    req_valid = 1'b1; req_addr = 8'h00;
    tick();
    check("stream0_valid", {63'b0, resp_valid}, 64'd1);
    req_addr = 8'h04;
    tick();
    req_valid = 1'b0;
    #1;
    check("stream1_valid", {63'b0, resp_valid}, 64'd1);
    check("stream1_fault", {63'b0, resp_fault}, 64'd0);
    tick();
    check("stream_drain", {63'b0, resp_valid}, 64'd0);

    // stall
    req_valid = 1'b1; req_addr = 8'h08; resp_ready = 1'b1;
    tick();
    req_addr = 8'h0C; resp_ready = 1'b0;
    held = resp_inst;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_ready", {63'b0, req_ready}, 64'd0);
      check("stall_inst", {32'b0, resp_inst}, {32'b0, held});
      tick();
    end
    resp_ready = 1'b1;
    #1;
    check("unstall_ready", {63'b0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    check("unstall_resp", {63'b0, resp_valid}, 64'd1);
    tick();

    // faults and range boundary
    fetch_one(8'h02);
    check("mis_fault", {63'b0, resp_fault}, 64'd1);
    check("mis_inst", {32'b0, resp_inst}, {32'b0, NOP});
    fetch_one(8'hFC);
    check("oor_fault", {63'b0, resp_fault}, 64'd1);
    fetch_one(8'h80);
    check("edge_oor_fault", {63'b0, resp_fault}, 64'd1);
    fetch_one(8'h7C);
    check("edge_ok_fault", {63'b0, resp_fault}, 64'd0);
    tick();

`ifdef IMEM_LOAD_EN
    // full load with gaps
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    load_words(32'hA000_0000, DEPTH, dones);
    check("load_done_pulses", 64'(dones), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      fetch_one(8'(i * 4));
      check("readback", {32'b0, resp_inst}, {32'b0, 32'hA000_0000 + 32'(i)});
    end
    tick();

    // restart after five words; ld_valid alongside ld_start is ignored
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    load_words(32'hB000_0000, 5, dones);
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    check("reload_busy", {63'b0, ld_busy_o}, 64'd1);
    load_words(32'hC000_0000, DEPTH, dones);
    check("reload_done_pulses", 64'(dones), 64'd1);
    fetch_one(8'h00);
    check("reload_word0", {32'b0, resp_inst}, {32'b0, 32'hC000_0000});
    fetch_one(8'h14);
    check("reload_word5", {32'b0, resp_inst}, {32'b0, 32'hC000_0005});
    tick();

    rand_traffic(600, 1);
`else
    rand_traffic(400, 0);
`endif

    req_valid = 1'b0; resp_ready = 1'b1;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
